// File: rtl/memory_island_pkg.sv
// Shared types for the memory island bank front end.
// Request/tag bundles and the response source encoding.
package memory_island_pkg;

  typedef struct packed {
    int unsigned AddrWidth;
    int unsigned DataWidth;
  } mem_cfg_t;

  localparam mem_cfg_t MemCfg = '{AddrWidth: 10, DataWidth: 32};

  localparam int unsigned MemAw = MemCfg.AddrWidth;
  localparam int unsigned MemDw = MemCfg.DataWidth;
  localparam int unsigned MemSw = MemDw / 8;

  typedef enum logic {
    SRC_NARROW = 1'b0,
    SRC_WIDE   = 1'b1
  } src_e;

  typedef struct packed {
    logic             we;
    logic [MemAw-1:0] addr;
    logic [MemDw-1:0] wdata;
    logic [MemSw-1:0] be;
  } mem_req_t;

  typedef struct packed {
    logic valid;
    src_e src;
  } mem_tag_t;

  function automatic int unsigned cnt_width(int unsigned max_val);
    return (max_val == 0) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/memory_island_tag_pipe.sv
// Generic N-stage valid/payload shift register.
// Synchronous clear drops every in-flight entry.
module memory_island_tag_pipe
  import memory_island_pkg::*;
#(
  parameter int unsigned Depth = 1,
  parameter int unsigned Width = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  input  logic [Width-1:0] data_i,
  output logic             valid_o,
  output logic [Width-1:0] data_o
);

  logic [Depth-1:0]            valid_d, valid_q;
  logic [Depth-1:0][Width-1:0] data_d, data_q;

  always_comb begin
    valid_d    = '0;
    data_d     = '0;
    valid_d[0] = valid_i;
    data_d[0]  = data_i;
    for (int i = 1; i < Depth; i++) begin
      valid_d[i] = valid_q[i-1];
      data_d[i]  = data_q[i-1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q[Depth-1];
  assign data_o  = data_q[Depth-1];

endmodule

// File: rtl/memory_island_bank_arbiter.sv
// Per-bank arbiter: narrow and wide-slice ports onto one SRAM bank.
// Narrow wins by default; a wait counter lifts a starved wide port.
module memory_island_bank_arbiter
  import memory_island_pkg::*;
#(
  parameter int unsigned AddrWidth         = 10,
  parameter int unsigned DataWidth         = 32,
  parameter int unsigned StrbWidth         = DataWidth / 8,
  parameter int unsigned BankAccessLatency = 1,
  parameter int unsigned WidePriorityWait  = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 narrow_req_i,
  output logic                 narrow_gnt_o,
  input  logic                 narrow_we_i,
  input  logic [AddrWidth-1:0] narrow_addr_i,
  input  logic [DataWidth-1:0] narrow_wdata_i,
  input  logic [StrbWidth-1:0] narrow_be_i,
  output logic                 narrow_rvalid_o,
  output logic [DataWidth-1:0] narrow_rdata_o,
  input  logic                 wide_req_i,
  output logic                 wide_gnt_o,
  input  logic                 wide_we_i,
  input  logic [AddrWidth-1:0] wide_addr_i,
  input  logic [DataWidth-1:0] wide_wdata_i,
  input  logic [StrbWidth-1:0] wide_be_i,
  output logic                 wide_rvalid_o,
  output logic [DataWidth-1:0] wide_rdata_o,
  output logic                 bank_req_o,
  output logic                 bank_we_o,
  output logic [AddrWidth-1:0] bank_addr_o,
  output logic [DataWidth-1:0] bank_wdata_o,
  output logic [StrbWidth-1:0] bank_be_o,
  input  logic [DataWidth-1:0] bank_rdata_i
);

  localparam int unsigned CntW = cnt_width(WidePriorityWait);
  localparam logic [CntW-1:0] CntMax = CntW'(WidePriorityWait);

  if (BankAccessLatency < 1) begin : g_lat_chk
    $error("BankAccessLatency must be >= 1");
  end

  typedef struct packed {
    logic                 we;
    logic [AddrWidth-1:0] addr;
    logic [DataWidth-1:0] wdata;
    logic [StrbWidth-1:0] be;
  } req_t;

  req_t     narrow_req, wide_req, bank_req;
  logic     wide_prio;
  logic     tag_valid, tag_src;
  mem_tag_t tag;

  logic [CntW-1:0] wait_cnt_d, wait_cnt_q;

  assign narrow_req = '{narrow_we_i, narrow_addr_i, narrow_wdata_i, narrow_be_i};
  assign wide_req   = '{wide_we_i, wide_addr_i, wide_wdata_i, wide_be_i};

  assign wide_prio = (WidePriorityWait != 0) && (wait_cnt_q >= CntMax);

  // Nothing is granted while reset is held.
  assign narrow_gnt_o = narrow_req_i && !rst_i && !(wide_req_i && wide_prio);
  assign wide_gnt_o   = wide_req_i && !rst_i && (!narrow_req_i || wide_prio);
  assign bank_req_o   = narrow_gnt_o || wide_gnt_o;

  always_comb begin
    bank_req = '0;
    unique case (1'b1)
      narrow_gnt_o: bank_req = narrow_req;
      wide_gnt_o:   bank_req = wide_req;
      default:      bank_req = '0;
    endcase
  end

  assign bank_we_o    = bank_req.we;
  assign bank_addr_o  = bank_req.addr;
  assign bank_wdata_o = bank_req.wdata;
  assign bank_be_o    = bank_req.be;

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!wide_req_i || wide_gnt_o) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q < CntMax) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end

  memory_island_tag_pipe #(
    .Depth(BankAccessLatency),
    .Width(1)
  ) u_tag_pipe (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .valid_i(bank_req_o),
    .data_i (wide_gnt_o),
    .valid_o(tag_valid),
    .data_o (tag_src)
  );

  assign tag.valid = tag_valid;
  assign tag.src   = src_e'(tag_src);

  // Responses still in the pipe when reset arrives are suppressed.
  assign narrow_rvalid_o = tag.valid && (tag.src == SRC_NARROW) && !rst_i;
  assign wide_rvalid_o   = tag.valid && (tag.src == SRC_WIDE) && !rst_i;
  assign narrow_rdata_o  = bank_rdata_i;
  assign wide_rdata_o    = bank_rdata_i;

endmodule

// File: doc/memory_island_bank_arbiter.md
Name: memory_island_bank_arbiter

Overview:
- Per-bank front end of the memory island. Arbitrates one narrow requestor port and one wide-slice requestor port onto a single SRAM bank of narrow data width.
- Tracks in-flight accesses through a BankAccessLatency-deep tag pipeline and returns each response to the port that issued it.
- Narrow requests have default priority. A starvation counter hands priority to the wide port after WidePriorityWait blocked cycles.
- One instance per bank. Instantiated (NarrowDataWidth/WideDataWidth-derived) NumWideBanks*WideDataWidth/NarrowDataWidth times.

Parameters:
- AddrWidth, 10, bank word-address width (log2 WordsPerBank).
- DataWidth, 32, bank word width (equals NarrowDataWidth).
- StrbWidth, DataWidth/8, byte-enable width (derived; do not override).
- BankAccessLatency, 1, cycles from bank request to valid bank_rdata_i. Must be >= 1.
- WidePriorityWait, 4, blocked-cycle threshold before wide wins. 0 = wide never gains priority.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- narrow_req_i  in  1  narrow request valid.
- narrow_gnt_o  out  1  narrow request accepted this cycle.
- narrow_we_i  in  1  write enable.
- narrow_addr_i  in  AddrWidth  word address.
- narrow_wdata_i  in  DataWidth  write data.
- narrow_be_i  in  StrbWidth  byte enables.
- narrow_rvalid_o  out  1  response valid (read data or write ack).
- narrow_rdata_o  out  DataWidth  read data.
- wide_req_i, wide_gnt_o, wide_we_i, wide_addr_i, wide_wdata_i, wide_be_i, wide_rvalid_o, wide_rdata_o: same widths and meaning, for the wide-slice port.
- bank_req_o  out  1  bank access strobe.
- bank_we_o  out  1  bank write enable.
- bank_addr_o  out  AddrWidth  bank address.
- bank_wdata_o  out  DataWidth  bank write data.
- bank_be_o  out  StrbWidth  bank byte enables.
- bank_rdata_i  in  DataWidth  bank read data, valid BankAccessLatency cycles after bank_req_o.

Behaviour:
- Handshake: TCDM-style. Grant is combinational in the same cycle as the request. A request is consumed when req && gnt. The requestor holds its request stable until granted. There is no backpressure on responses.
- Arbitration (combinational):
  - Only one port requesting: that port is granted.
  - Both ports requesting: narrow wins unless wide_prio=1.
  - wide_prio = (WidePriorityWait != 0) && (wait_cnt >= WidePriorityWait).
- bank_req_o = narrow_gnt_o | wide_gnt_o. The bank_* fields are muxed from the winning port. When idle, bank_* fields are 0.
- wait_cnt: width $clog2(WidePriorityWait+1), minimum 1 bit.
  - +1 each cycle wide_req_i && !wide_gnt_o, saturating at WidePriorityWait.
  - Cleared to 0 on any wide grant, or any cycle with wide_req_i=0.
- Tag pipeline: BankAccessLatency stages of {valid, src} (src 0 = narrow, 1 = wide). Stage 0 loads {bank_req_o, wide_gnt_o} each cycle. The last stage drives the responses:
  - narrow_rvalid_o = valid && !src.
  - wide_rvalid_o = valid && src.
  - Both rdata outputs = bank_rdata_i directly (unregistered, no mux). rdata is meaningful only for reads.
- Latency: response is asserted exactly BankAccessLatency cycles after the grant, for reads and writes alike. One access per cycle. Full throughput with back-to-back grants.
- Reset values: all tag stages invalid, wait_cnt = 0, both rvalid outputs = 0. Grants and bank_* are combinational and are 0 when no request is present.
- Reset mid-operation: in-flight tags are discarded. No response is emitted for accesses granted before or during reset. Requests asserted while rst_i=1 are not granted.
- Simultaneous events: a wide grant on the same cycle wait_cnt would increment → wait_cnt = 0. A narrow request denied because of wide_prio is simply held by the requestor; the module has no narrow starvation counter.
- Elaboration: assertion BankAccessLatency >= 1.

Decomposition:
- Shared package memory_island_pkg:
  - typedef mem_req_t {we, addr, wdata, be}, parameterised via localparams from the mem_cfg_t instance.
  - typedef mem_tag_t {valid, src}.
  - Enum for src encoding (SRC_NARROW = 0, SRC_WIDE = 1).
- One natural sub-module: memory_island_tag_pipe, a generic N-stage valid/payload shift register with synchronous clear. Reusable for the SpillReqBank/SpillRspBank stages.

Test Plan:
- Narrow-only read, latency 1: narrow_req_i=1, addr=0x05 at cycle 0 → narrow_gnt_o=1 and bank_addr_o=0x05 at cycle 0; narrow_rvalid_o=1 with bank data 0xDEADBEEF at cycle 1; wide_rvalid_o stays 0.
- Contention, WidePriorityWait=4: both ports request continuously → narrow granted cycles 0–3, wide granted cycle 4, wait_cnt back to 0, narrow granted cycles 5–8, wide granted cycle 9.
- WidePriorityWait=0: both ports request for 20 cycles → narrow granted every cycle, wide_gnt_o never 1.
- BankAccessLatency=3, alternating grants N, W, N → rvalids at cycles 3, 4, 5 in order narrow, wide, narrow, each with matching bank_rdata_i.
- Write ack: wide write, be=4'b0011, wdata=0x12345678 → bank_we_o=1 and bank_be_o=4'b0011 in the grant cycle; wide_rvalid_o=1 one latency later.
- Reset mid-flight, latency 2: grant at cycle 0, rst_i=1 at cycle 1 → no rvalid at cycle 2; wait_cnt=0 after reset.
